// File: rtl/shift_reg_sipo_deser.sv
// -----------------------------------------------------------------------------
// shift_reg_sipo_deser
//
// Serial-in / parallel-out deserializer. Qualified serial bits are collected
// into WIDTH-bit words. Each completed word is presented on a registered
// parallel bus together with a one-cycle valid strobe. The bus holds its value
// until the next word completes, so partial words are never visible on it.
//
// Ports
//   clk               : system clock, rising-edge active
//   reset             : asynchronous active-low reset (0 = reset asserted)
//   serial_in         : serial data bit, sampled only when serial_valid = 1
//   serial_valid      : qualifies serial_in on this edge; gaps are allowed
//   clear             : synchronous flush of the partial word; the bus is kept
//   parallel_data_out : last completed word, registered
//   data_valid        : one-cycle strobe, high when the bus was updated at the
//                       previous edge
//   busy              : high while a partial word is held
//   bit_count         : number of bits accepted into the current partial word
// -----------------------------------------------------------------------------
module shift_reg_sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] parallel_data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Count value at which the incoming bit completes the word.
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic [WIDTH-1:0] pdo_q, pdo_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shifted_s;

  // Insert one bit into the partial word in the configured arrival order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic             b);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {sr[WIDTH-2:0], b};
    end else begin
      r = {b, sr[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Next-state logic: clear has priority over a valid bit, which has priority
  // over hold.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_count_d  = bit_count_q;
    pdo_d        = pdo_q;
    data_valid_d = 1'b0;
    shifted_s    = shift_in(sr_q, serial_in);

    if (clear) begin
      // A bit presented on this edge is discarded together with the partial word.
      sr_d        = {WIDTH{1'b0}};
      bit_count_d = {CW{1'b0}};
      state_d     = IDLE;
    end else if (serial_valid) begin
      if (bit_count_q == LAST_COUNT) begin
        // The completed word includes this bit. The shifter restarts empty,
        // so the next word can begin on the very next edge.
        pdo_d        = shifted_s;
        data_valid_d = 1'b1;
        sr_d         = {WIDTH{1'b0}};
        bit_count_d  = {CW{1'b0}};
        state_d      = IDLE;
      end else begin
        sr_d        = shifted_s;
        bit_count_d = bit_count_q + CW'(1);
        state_d     = SHIFT;
      end
    end else begin
      state_d = state_q;
    end

    // busy is registered alongside the state, so it follows state_d.
    case (state_d)
      SHIFT:   busy_d = 1'b1;
      IDLE:    busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sr_q         <= {WIDTH{1'b0}};
      bit_count_q  <= {CW{1'b0}};
      pdo_q        <= {WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_count_q  <= bit_count_d;
      pdo_q        <= pdo_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign parallel_data_out = pdo_q;
  assign data_valid        = data_valid_q;
  assign busy              = busy_q;
  assign bit_count         = bit_count_q;

endmodule

// File: tb/tb_shift_reg_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_sipo_deser
//
// Drives an MSB-first and an LSB-first instance (WIDTH=4) with the same
// stimulus. Expected outputs come from a queue-based model of the word
// assembly, from a hand-written vector table, and from explicit checks on the
// multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_shift_reg_sipo_deser;

  localparam int W  = 4;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          serial_in = 1'b0;
  logic          serial_valid = 1'b0;
  logic          clear = 1'b0;

  logic [W-1:0]  pdo_m, pdo_l;
  logic          dv_m, dv_l, busy_m, busy_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit           m_q[$];
  logic [W-1:0] m_msb = '0;
  logic [W-1:0] m_lsb = '0;
  logic         m_dv = 1'b0;

  shift_reg_sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .clear(clear), .parallel_data_out(pdo_m), .data_valid(dv_m), .busy(busy_m),
    .bit_count(cnt_m)
  );

  shift_reg_sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .clear(clear), .parallel_data_out(pdo_l), .data_valid(dv_l), .busy(busy_l),
    .bit_count(cnt_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_msb = '0;
    m_lsb = '0;
    m_dv  = 1'b0;
  endtask

  // Word assembly from the arrival order of the bits: the i-th received bit
  // ends up at position W-1-i (MSB first) or i (LSB first).
  task automatic model_edge(input logic sv, input logic si, input logic clr);
    m_dv = 1'b0;
    if (clr) begin
      m_q.delete();
    end else if (sv) begin
      m_q.push_back(si);
      if (m_q.size() == W) begin
        m_msb = '0;
        m_lsb = '0;
        for (int i = 0; i < W; i++) begin
          if (m_q[i]) begin
            m_msb = m_msb | (W'(1) << (W - 1 - i));
            m_lsb = m_lsb | (W'(1) << i);
          end
        end
        m_dv = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pdo_msb"}, 32'(pdo_m), 32'(m_msb));
    check({tag, "_pdo_lsb"}, 32'(pdo_l), 32'(m_lsb));
    check({tag, "_dv"},      32'({dv_m, dv_l}), 32'({m_dv, m_dv}));
    check({tag, "_cnt"},     32'({cnt_m, cnt_l}), 32'({CW'(m_q.size()), CW'(m_q.size())}));
    check({tag, "_busy"},    32'({busy_m, busy_l}),
          32'({m_q.size() != 0, m_q.size() != 0}));
  endtask

  // One clock: drive inputs, advance the model at the edge, sample 1 ns later.
  task automatic tick(input logic sv, input logic si, input logic clr, input string tag);
    serial_valid = sv;
    serial_in    = si;
    clear        = clr;
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(sv, si, clr);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic          sv;
    logic          si;
    logic          clr;
    logic [W-1:0]  pdo;
    logic          dv;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // MSB-first single word 1,0,0,0 then one idle cycle
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 3'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'h8, 1'b1, 3'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h8, 1'b0, 3'd0};
    // Back-to-back words 1010, 1100, 1011
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'h8, 1'b0, 3'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'h8, 1'b0, 3'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'h8, 1'b0, 3'd3};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 3'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 3'd1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 3'd2};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 3'd3};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'hC, 1'b1, 3'd0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'hC, 1'b0, 3'd1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 3'd2};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 4'hC, 1'b0, 3'd3};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 3'd0};

    // Reset held for two cycles while inputs toggle
    reset = 1'b0;
    tick(1'b1, 1'b1, 1'b0, "rst0");
    tick(1'b1, 1'b0, 1'b0, "rst1");
    check("rst_all_zero", 32'({pdo_m, pdo_l, dv_m, dv_l, busy_m, busy_l, cnt_m, cnt_l}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0, "post_rst");
    check("post_rst_zero", 32'({pdo_m, dv_m, busy_m, cnt_m}), 32'd0);

    // Table-driven MSB-first vectors
    for (int i = 0; i < 17; i++) begin
      tick(vecs[i].sv, vecs[i].si, vecs[i].clr, "vec");
      check($sformatf("vec%0d_pdo", i), 32'(pdo_m), 32'(vecs[i].pdo));
      check($sformatf("vec%0d_dv", i), 32'(dv_m), 32'(vecs[i].dv));
      check($sformatf("vec%0d_cnt", i), 32'(cnt_m), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_busy", i), 32'(busy_m), 32'(vecs[i].cnt != 3'd0));
    end

    // Gapped input: 1,1, three idle cycles, 0,1
    tick(1'b1, 1'b1, 1'b0, "gap");
    tick(1'b1, 1'b1, 1'b0, "gap");
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, "gap_idle");
      check("gap_cnt_hold", 32'(cnt_m), 32'd2);
    end
    tick(1'b1, 1'b0, 1'b0, "gap");
    tick(1'b1, 1'b1, 1'b0, "gap");
    check("gap_word_msb", 32'(pdo_m), 32'hD);
    check("gap_word_lsb", 32'(pdo_l), 32'hB);
    check("gap_dv", 32'(dv_m), 32'd1);

    // Clear together with a valid bit after 1,0,1
    tick(1'b1, 1'b1, 1'b0, "clr");
    tick(1'b1, 1'b0, 1'b0, "clr");
    tick(1'b1, 1'b1, 1'b0, "clr");
    tick(1'b1, 1'b1, 1'b1, "clr_edge");
    check("clr_state", 32'({cnt_m, busy_m, dv_m}), 32'd0);
    check("clr_bus_kept", 32'(pdo_m), 32'hD);
    tick(1'b1, 1'b0, 1'b0, "after_clr");
    tick(1'b1, 1'b1, 1'b0, "after_clr");
    tick(1'b1, 1'b1, 1'b0, "after_clr");
    tick(1'b1, 1'b0, 1'b0, "after_clr");
    check("after_clr_word", 32'(pdo_m), 32'h6);

    // Mid-word reset pulsed between edges
    tick(1'b1, 1'b1, 1'b0, "mid");
    tick(1'b1, 1'b1, 1'b0, "mid");
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_bus", 32'({pdo_m, pdo_l}), 32'd0);
    check("mid_rst_cnt", 32'({cnt_m, busy_m}), 32'd0);
    model_reset();
    #1;
    reset = 1'b1;

    // LSB-first word 1,0,0,0
    tick(1'b1, 1'b1, 1'b0, "lsb");
    tick(1'b1, 1'b0, 1'b0, "lsb");
    tick(1'b1, 1'b0, 1'b0, "lsb");
    tick(1'b1, 1'b0, 1'b0, "lsb");
    check("lsb_word", 32'(pdo_l), 32'h1);
    check("lsb_dv", 32'(dv_l), 32'd1);
    tick(1'b0, 1'b0, 1'b0, "lsb_idle");
    check("lsb_dv_drop", 32'(dv_l), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
